ex_muldiv: RTL and testbench

Iterative RV32M/RV64M multiply-divide execute unit, parametrised in data width. It sits in parallel with the single-cycle EX ALU. It accepts one M-extension operation through a valid/ready handshake and computes it over multiple cycles with a shift-add multiplier or a restoring divider. While busy it raises a stall request to the pipeline control, and it presents the result to the EX/MEM register through a second valid/ready handshake.

---
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv.sv | 155 +++++++++++++++
 tb/tb_ex_muldiv.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Issue/result handshake bundle between the pipeline and the iterative M-extension unit.
interface ex_muldiv_if #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_LEN = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              op;
    logic [XLEN-1:0]         rs1_val;
    logic [XLEN-1:0]         rs2_val;
    logic [REG_ADDR_LEN-1:0] rd_addr_i;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         rd_data_o;
    logic [REG_ADDR_LEN-1:0] rd_addr_o;
    logic                    rd_enable_o;
    logic                    stall_req;

    modport master (
        output in_valid, op, rs1_val, rs2_val, rd_addr_i, out_ready,
        input  in_ready, out_valid, rd_data_o, rd_addr_o, rd_enable_o, stall_req
    );

    modport slave (
        input  in_valid, op, rs1_val, rs2_val, rd_addr_i, out_ready,
        output in_ready, out_valid, rd_data_o, rd_addr_o, rd_enable_o, stall_req
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M execute unit: 1-bit/cycle shift-add multiply and restoring divide
// on operand magnitudes, with sign correction applied when the result is registered.
module ex_muldiv #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_LEN = 5
) (
    input logic        clk,
    input logic        rst,
    input logic        flush,
    ex_muldiv_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    op_e                     op_q, op_d;
    logic [2*XLEN-1:0]       acc_q, acc_d;
    logic [XLEN-1:0]         mag_b_q, mag_b_d;
    logic                    neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic [REG_ADDR_LEN-1:0] rd_pend_q, rd_pend_d;
    logic [XLEN-1:0]         rd_data_q, rd_data_d;
    logic [REG_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;

    op_e               op_in;
    logic              a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_val;
    logic [XLEN:0]     mul_sum, mul_add, div_shift, div_trial;
    logic [2*XLEN-1:0] step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, result;

    always_comb begin
        op_in    = op_e'(bus.op);
        a_signed = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        b_signed = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                   (op_in == OP_DIV) || (op_in == OP_REM);
        sa       = a_signed & bus.rs1_val[XLEN-1];
        sb       = b_signed & bus.rs2_val[XLEN-1];
        mag_a    = sa ? -bus.rs1_val : bus.rs1_val;
        mag_b    = sb ? -bus.rs2_val : bus.rs2_val;
        div_zero = bus.op[2] && (bus.rs2_val == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (bus.rs1_val == SMIN) && (bus.rs2_val == '1);
        if (div_zero) special_val = bus.op[1] ? bus.rs1_val : '1;
        else          special_val = bus.op[1] ? '0 : bus.rs1_val;
    end

    // One iteration. Multiply: low half holds the shrinking multiplier, high half the
    // partial product. Divide: high half is the remainder, low half shifts dividend out
    // and quotient bits in.
    always_comb begin
        mul_add   = acc_q[0] ? {1'b0, mag_b_q} : '0;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + mul_add;
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, mag_b_q};
        if (!op_q[2])            step = {mul_sum, acc_q[XLEN-1:1]};
        else if (!div_trial[XLEN]) step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                     step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        prod_fix = neg_q ? -step : step;
        quo_fix  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem_fix  = rem_neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result = quo_fix;
            OP_REM, OP_REMU:               result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mag_b_d   = mag_b_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        rd_pend_d = rd_pend_q;
        rd_data_d = rd_data_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                op_d      = op_in;
                rd_pend_d = bus.rd_addr_i;
                acc_d     = {{XLEN{1'b0}}, mag_a};
                mag_b_d   = mag_b;
                neg_d     = sa ^ sb;
                rem_neg_d = sa;
                if (div_zero || div_ovf) begin
                    rd_data_d = special_val;
                    rd_addr_d = bus.rd_addr_i;
                    state_d   = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    rd_data_d = result;
                    rd_addr_d = rd_pend_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Flush blocks both accept and any result load in the same cycle.
        if (flush) begin
            state_d   = S_IDLE;
            rd_data_d = rd_data_q;
            rd_addr_d = rd_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            acc_q     <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            rd_pend_q <= '0;
            rd_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            rd_pend_q <= rd_pend_d;
            rd_data_q <= rd_data_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.rd_data_o   = rd_data_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.rd_enable_o = (state_q == S_DONE) && (rd_addr_q != '0);
    assign bus.stall_req   = (state_q == S_CALC) || ((state_q == S_DONE) && !bus.out_ready);
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (XLEN=32): arithmetic reference model plus literal expectations.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    ex_muldiv_if #(.XLEN(32), .REG_ADDR_LEN(5)) bus ();
    ex_muldiv #(.XLEN(32), .REG_ADDR_LEN(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle and run the scoreboard on the settled outputs.
    task automatic tick();
        bit pop;
        pop = bus.out_valid && bus.out_ready && !flush && !rst;
        @(negedge clk);
        cyc++;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid at cycle %0d: got out_valid 1 expected 0", cyc);
            end else begin
                chk("sb_data", bus.rd_data_o, q[0].data);
                chk("sb_rd", bus.rd_addr_o, q[0].rd);
                chk("sb_rd_enable", bus.rd_enable_o, q[0].rd != 5'd0);
            end
        end
    endtask

    task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input bit push);
        int w;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.rs1_val   = a;
        bus.rs2_val   = b;
        bus.rd_addr_i = rd;
        w = 0;
        while (!bus.in_ready && w < 200) begin tick(); w++; end
        chk("accept_wait", w < 200, 1);
        if (push) q.push_back('{model(op, a, b), rd});
        tick();
        bus.in_valid  = 1'b0;
        bus.op        = 3'($urandom);
        bus.rs1_val   = $urandom;
        bus.rs2_val   = $urandom;
        bus.rd_addr_i = 5'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input int hold);
        int n;
        bit stall_ok;
        bus.out_ready = (hold == 0);
        accept_op(op, a, b, rd, 1'b1);
        n = 1;
        stall_ok = 1'b1;
        while (!bus.out_valid && n < 100) begin
            if (!bus.stall_req) stall_ok = 1'b0;
            tick();
            n++;
        end
        chk("latency", n, lat);
        chk("stall_calc", stall_ok, 1);
        chk("lit_data", bus.rd_data_o, exp);
        chk("stall_done", bus.stall_req, hold > 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.rd_data_o, exp);
            chk("hold_stall", bus.stall_req, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("valid_drop", bus.out_valid, 0);
        chk("ready_back", bus.in_ready, 1);
        chk("data_holds", bus.rd_data_o, exp);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 3'd0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd_addr_i = '0;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_rd_enable", bus.rd_enable_o, 0);
        chk("rst_stall", bus.stall_req, 0);
        chk("rst_rd_data", bus.rd_data_o, 0);
        chk("rst_rd_addr", bus.rd_addr_o, 0);
        rst = 1'b0;
        tick();

        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33, 0);
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'hC000_0000, 33, 0);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, 33, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 33, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33, 0);
        run_op(3'd4, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33, 0);
        run_op(3'd6, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'h0000_0001, 33, 0);
        run_op(3'd5, 32'd100,       32'd7,         5'd14, 32'd14,        33, 0);
        run_op(3'd7, 32'd100,       32'd7,         5'd15, 32'd2,         33, 0);
        run_op(3'd7, 32'hFFFF_FFFF, 32'h10,        5'd16, 32'hF,         33, 0);
        run_op(3'd5, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1,  0);
        run_op(3'd6, 32'd5,         32'd0,         5'd18, 32'd5,         1,  0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1,  0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1,  0);
        run_op(3'd0, 32'h1234_5678, 32'd9,         5'd21, 32'hA3D7_0A38, 33, 5);
        run_op(3'd5, 32'd1000,      32'd10,        5'd0,  32'd100,       33, 0);

        // Flush a DIV at cycle 10 while a new op is offered: nothing completes.
        accept_op(3'd4, 32'd1000, 32'd3, 5'd3, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 3'd0;
        bus.rs1_val = 32'd3;
        bus.rs2_val = 32'd4;
        bus.rd_addr_i = 5'd4;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_stall", bus.stall_req, 0);
        chk("flush_rd_data", bus.rd_data_o, 32'd100);
        repeat (40) tick();
        run_op(3'd0, 32'd3, 32'd4, 5'd4, 32'd12, 33, 0);

        // Reset mid-CALC aborts the operation.
        accept_op(3'd0, 32'd11, 32'd13, 5'd22, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_rd_enable", bus.rd_enable_o, 0);
        chk("mrst_stall", bus.stall_req, 0);
        chk("mrst_rd_data", bus.rd_data_o, 0);
        chk("mrst_rd_addr", bus.rd_addr_o, 0);
        rst = 1'b0;
        repeat (40) tick();
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd23, 32'hFFFF_FFF2, 33, 0);

        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
